decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
- Parametrised second-generation ID stage for the 16-bit MISC-V pipeline.
- Contains the IF/ID pipeline register (with stall and flush), an 8-entry register file with write-through, and control and immediate decode.
- Resolves branches and jumps early in ID using forwarded operands, with load-use and branch-use hazard interlocks.
- Drives a registered ID/EX bundle with a valid bit. Sits between fetch and execute.

Parameters:
- DATA_W, 16, register/operand width (≥16); immediates sign-extended to DATA_W.
- PC_W, 16, program-counter width; pc arithmetic wraps modulo 2^PC_W.
- R0_ZERO, 1, when 1, register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- pc_in  in  PC_W  pc of the fetched instruction.
- pcp2_in  in  PC_W  pc_in+2 from fetch.
- ir_in  in  16  fetched instruction.
- wb_we  in  1  writeback enable.
- wb_addr  in  3  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_memread  in  1  instruction currently in EX is a load.
- ex_regwrite  in  1  instruction currently in EX writes a register.
- ex_rd  in  3  EX destination register.
- fwd1_sel  in  1  1 selects fwd1_data for comparator operand 1.
- fwd2_sel  in  1  1 selects fwd2_data for comparator operand 2.
- fwd1_data  in  DATA_W  forwarded value for operand 1 (from MEM).
- fwd2_data  in  DATA_W  forwarded value for operand 2 (from MEM).
- stall_out  out  1  fetch must hold pc and ir_in.
- redirect  out  1  fetch must load new_pc.
- new_pc  out  PC_W  redirect target.
- ex_valid  out  1  ID/EX bundle valid.
- ex_pcp2  out  PC_W  registered bundle field.
- ex_rs1v  out  DATA_W  registered bundle field.
- ex_rs2v  out  DATA_W  registered bundle field.
- ex_imm  out  DATA_W  registered bundle field.
- ex_rs1  out  3  registered bundle field.
- ex_rs2  out  3  registered bundle field.
- ex_rd_o  out  3  registered bundle field.
- ex_aluop  out  3  registered bundle field.
- ex_alusrc  out  1  registered bundle field.
- ex_memwrite  out  1  registered bundle field.
- ex_memread_o  out  1  registered bundle field.
- ex_regwrite_o  out  1  registered bundle field.
- ex_link  out  1  registered bundle field.

Behaviour:
- Reset (async, reset=0): IF/ID valid=0, ir=0, pc=0; all registers 0; every ex_* output 0; stall_out, redirect and new_pc read as 0.
- Fields: opcode=ir[2:0], rd=ir[5:3], rs1=ir[8:6], rs2=ir[11:9], func=ir[15:12].
- Opcode 000, R-ALU: aluop=func[2:0], regwrite=1.
- Opcode 001, I-ALU: alusrc=1, aluop=func[2:0], imm=sext(ir[15:9]), regwrite=1.
- Opcode 010, load: alusrc=1, memread=1, regwrite=1, imm=sext(ir[15:9]).
- Opcode 011, store: alusrc=1, memwrite=1, imm=sext({ir[15:12],ir[5:3]}).
- Opcodes 100/101/110, BEQ/BNE/BLT: BLT is a signed compare; imm=sext({ir[15:12],ir[5:3]}); target=pc+(imm<<1).
- Opcode 111, JAL-R: target=op1+imm with imm=sext(ir[15:9]); link=1, regwrite=1, writes pcp2 to rd in WB.
- Register file: combinational reads; synchronous write on wb_we. A same-cycle write to a read address returns wb_data (write-through).
- Comparator operands: op1 = fwd1_sel ? fwd1_data : rf[rs1]; op2 = fwd2_sel ? fwd2_data : rf[rs2].
- Hazard condition: hz = IF/ID valid & ex_regwrite & ex_rd≠0 & ex_rd ∈ {used rs1, used rs2}, AND (ex_memread OR the ID instruction is a branch/jump).
  - Used sources: R-ALU/store/branch use rs1 and rs2; I-ALU/load/JAL-R use rs1 only.
- When hz: stall_out=1, IF/ID holds, the next ID/EX gets a bubble (ex_valid=0 and all control fields 0), redirect=0.
  - One stall cycle per hazard; the condition re-evaluates each cycle.
- redirect = IF/ID valid & !hz & (taken branch or jump). new_pc=target, otherwise 0.
- On redirect, at the next edge: IF/ID loads a bubble (valid=0, ir=0) regardless of if_valid. Flush has priority over a simultaneous stall.
- IF/ID update priority: redirect flush > stall hold > load (valid=if_valid).
- ID/EX latency: 1 cycle. The bundle captures the decode of the current IF/ID contents when valid & !hz.
- Branches and jumps still pass to EX valid, with memwrite=0 and regwrite=link.
- Wrap-around: pc+(imm<<1) truncates to PC_W with no overflow flag. With R0_ZERO=1, register 0 never compares as a hazard.

Optional Feature:
- Macro DECODE_PERF_CNT_EN. When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each cycle with hz=1; flush_cnt increments on each redirect.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-stream with reset=0 for 1 cycle while valid instructions flow -> ex_valid=0, all ex_* =0, r1..r7 read 0 immediately.
- WB r3=16'h00A5 in the same cycle ID reads r3 -> ex_rs1v=16'h00A5 next edge.
- Load r2 in EX, then ADD r4,r2,r1 in ID -> stall_out=1 for 1 cycle, one bubble (ex_valid=0), then ADD issues with ex_valid=1.
- BEQ r1,r2 with r1=r2=5, pc=16'h0010, imm=3 -> redirect=1, new_pc=16'h0016, next IF/ID valid=0 even with if_valid=1.
- BLT with r1=16'hFFFF (-1) vs r2=1 -> taken; the same operands with BNE and equal values -> not taken, redirect=0.
- JAL-R with r5=16'hFFFE, imm=4 and fwd1_sel=1/fwd1_data=16'h0100 -> new_pc=16'h0104; ex_link=1, ex_pcp2=pc+2.

Source files
------------

// File: rtl/decode_stage_p.sv
// decode_stage_p: ID stage for the 16-bit MISC-V pipeline.
// Holds the IF/ID register, an 8-entry register file with write-through,
// control/immediate decode, early branch/jump resolution and hazard interlocks.
// It drives a registered ID/EX bundle.
// Optional build macro: DECODE_PERF_CNT_EN adds the stall_cnt and flush_cnt counters.
//
// Handshake: if_valid qualifies ir_in/pc_in/pcp2_in. While stall_out=1,
// fetch holds those inputs and IF/ID keeps its contents. ex_valid qualifies
// the ID/EX bundle, and EX accepts it every cycle because there is no
// backpressure. redirect=1 means fetch loads new_pc at the next edge.
module decode_stage_p #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   pcp2_in,
  input  logic [15:0]       ir_in,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [2:0]        ex_rd,
  input  logic              fwd1_sel,
  input  logic              fwd2_sel,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic [DATA_W-1:0] fwd2_data,
  output logic              stall_out,
  output logic              redirect,
  output logic [PC_W-1:0]   new_pc,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pcp2,
  output logic [DATA_W-1:0] ex_rs1v,
  output logic [DATA_W-1:0] ex_rs2v,
  output logic [DATA_W-1:0] ex_imm,
  output logic [2:0]        ex_rs1,
  output logic [2:0]        ex_rs2,
  output logic [2:0]        ex_rd_o,
  output logic [2:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_memwrite,
  output logic              ex_memread_o,
  output logic              ex_regwrite_o,
  output logic              ex_link
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [2:0] OP_RALU = 3'b000;
  localparam logic [2:0] OP_IALU = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_STOR = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_BLT  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  logic              id_valid;
  logic [15:0]       id_ir;
  logic [PC_W-1:0]   id_pc;
  logic [PC_W-1:0]   id_pcp2;
  logic [DATA_W-1:0] rf [8];

  logic [2:0]        opcode, rd, rs1, rs2;
  logic [6:0]        imm7_i, imm7_s;
  logic [DATA_W-1:0] imm_i, imm_s;
  logic [PC_W-1:0]   br_off, br_tgt, jal_tgt;
  logic [DATA_W-1:0] rs1_rf, rs2_rf, op1, op2;

  logic [DATA_W-1:0] d_imm;
  logic [2:0]        d_aluop;
  logic              d_alusrc, d_memwrite, d_memread, d_regwrite, d_link;
  logic              uses_rs2, is_ctrl, taken, hz;

  assign opcode = id_ir[2:0];
  assign rd     = id_ir[5:3];
  assign rs1    = id_ir[8:6];
  assign rs2    = id_ir[11:9];
  assign imm7_i = id_ir[15:9];
  assign imm7_s = {id_ir[15:12], id_ir[5:3]};
  assign imm_i  = {{(DATA_W-7){imm7_i[6]}}, imm7_i};
  assign imm_s  = {{(DATA_W-7){imm7_s[6]}}, imm7_s};

  // The branch offset is built at PC width so that pc arithmetic wraps naturally.
  assign br_off  = {{(PC_W-8){imm7_s[6]}}, imm7_s, 1'b0};
  assign br_tgt  = id_pc + br_off;
  assign jal_tgt = PC_W'(op1 + imm_i);

  // Register reads with write-through from the same-cycle writeback; r0 is optionally hard zero.
  always_comb begin
    rs1_rf = rf[rs1];
    rs2_rf = rf[rs2];
    if (wb_we && wb_addr == rs1) rs1_rf = wb_data;
    if (wb_we && wb_addr == rs2) rs2_rf = wb_data;
    if (R0_ZERO != 0 && rs1 == 3'd0) rs1_rf = '0;
    if (R0_ZERO != 0 && rs2 == 3'd0) rs2_rf = '0;
  end

  assign op1 = fwd1_sel ? fwd1_data : rs1_rf;
  assign op2 = fwd2_sel ? fwd2_data : rs2_rf;

  // Decode control fields, the immediate, which sources are used, and branch outcome.
  always_comb begin
    d_imm      = '0;
    d_aluop    = 3'd0;
    d_alusrc   = 1'b0;
    d_memwrite = 1'b0;
    d_memread  = 1'b0;
    d_regwrite = 1'b0;
    d_link     = 1'b0;
    uses_rs2   = 1'b0;
    is_ctrl    = 1'b0;
    taken      = 1'b0;
    case (opcode)
      OP_RALU: begin
        d_aluop = id_ir[14:12]; d_regwrite = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IALU: begin
        d_aluop = id_ir[14:12]; d_alusrc = 1'b1; d_imm = imm_i; d_regwrite = 1'b1;
      end
      OP_LOAD: begin
        d_alusrc = 1'b1; d_memread = 1'b1; d_regwrite = 1'b1; d_imm = imm_i;
      end
      OP_STOR: begin
        d_alusrc = 1'b1; d_memwrite = 1'b1; d_imm = imm_s; uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        d_imm = imm_s; uses_rs2 = 1'b1; is_ctrl = 1'b1; taken = (op1 == op2);
      end
      OP_BNE: begin
        d_imm = imm_s; uses_rs2 = 1'b1; is_ctrl = 1'b1; taken = (op1 != op2);
      end
      OP_BLT: begin
        d_imm = imm_s; uses_rs2 = 1'b1; is_ctrl = 1'b1;
        taken = ($signed(op1) < $signed(op2));
      end
      default: begin
        d_imm = imm_i; d_link = 1'b1; d_regwrite = 1'b1; is_ctrl = 1'b1; taken = 1'b1;
      end
    endcase
  end

  // Interlock: load-use always stalls; any EX producer stalls a branch/jump consumer.
  always_comb begin
    hz = id_valid && ex_regwrite && (ex_rd != 3'd0) &&
         ((ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)) &&
         (ex_memread || is_ctrl);
  end

  assign stall_out = hz;
  assign redirect  = id_valid && !hz && taken;
  assign new_pc    = redirect ? (opcode == OP_JALR ? jal_tgt : br_tgt) : '0;

  // IF/ID register: a flush takes priority over a stall, which takes priority over a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_ir    <= '0;
      id_pc    <= '0;
      id_pcp2  <= '0;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_ir    <= '0;
    end else if (!hz) begin
      id_valid <= if_valid;
      id_ir    <= ir_in;
      id_pc    <= pc_in;
      id_pcp2  <= pcp2_in;
    end
  end

  // Register file write port; r0 ignores writes when it is hard-wired to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_we && !(R0_ZERO != 0 && wb_addr == 3'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ID/EX bundle: capture the decode when issuing, otherwise insert an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !(id_valid && !hz)) begin
      ex_valid      <= 1'b0;
      ex_pcp2       <= '0;
      ex_rs1v       <= '0;
      ex_rs2v       <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd_o       <= '0;
      ex_aluop      <= '0;
      ex_alusrc     <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_regwrite_o <= 1'b0;
      ex_link       <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pcp2       <= id_pcp2;
      ex_rs1v       <= rs1_rf;
      ex_rs2v       <= rs2_rf;
      ex_imm        <= d_imm;
      ex_rs1        <= rs1;
      ex_rs2        <= rs2;
      ex_rd_o       <= rd;
      ex_aluop      <= d_aluop;
      ex_alusrc     <= d_alusrc;
      ex_memwrite   <= d_memwrite;
      ex_memread_o  <= d_memread;
      ex_regwrite_o <= d_regwrite;
      ex_link       <= d_link;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Saturating counters for stall cycles and redirect flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed-vector bench for decode_stage_p.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [15:0] pc_in, pcp2_in, ir_in;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_memread, ex_regwrite;
  logic [2:0]  ex_rd;
  logic        fwd1_sel, fwd2_sel;
  logic [15:0] fwd1_data, fwd2_data;
  logic        stall_out, redirect;
  logic [15:0] new_pc;
  logic        ex_valid;
  logic [15:0] ex_pcp2, ex_rs1v, ex_rs2v, ex_imm;
  logic [2:0]  ex_rs1, ex_rs2, ex_rd_o, ex_aluop;
  logic        ex_alusrc, ex_memwrite, ex_memread_o, ex_regwrite_o, ex_link;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_p dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .pc_in(pc_in), .pcp2_in(pcp2_in),
    .ir_in(ir_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .stall_out(stall_out), .redirect(redirect), .new_pc(new_pc), .ex_valid(ex_valid),
    .ex_pcp2(ex_pcp2), .ex_rs1v(ex_rs1v), .ex_rs2v(ex_rs2v), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd_o(ex_rd_o), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite), .ex_memread_o(ex_memread_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_link(ex_link)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [15:0] enc_r(input logic [3:0] func, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {func, rs2, rs1, rd, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [6:0] imm,
                                        input logic [2:0] rs1, input logic [2:0] rd);
    return {imm, rs1, rd, op};
  endfunction

  function automatic logic [15:0] enc_s(input logic [2:0] op, input logic [6:0] imm,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {imm[6:3], rs2, rs1, imm[2:0], op};
  endfunction

  // Driver tasks
  task automatic wb_write(input logic [2:0] addr, input logic [15:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic feed(input logic [15:0] pc, input logic [15:0] instr);
    if_valid = 1'b1; pc_in = pc; pcp2_in = pc + 16'd2; ir_in = instr;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic hz_inputs(input logic mr, input logic rw, input logic [2:0] rd);
    ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
    settle();
  endtask

  initial begin
    reset = 1'b0; if_valid = 1'b0; pc_in = '0; pcp2_in = '0; ir_in = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0;
    fwd1_sel = 1'b0; fwd2_sel = 1'b0; fwd1_data = '0; fwd2_data = '0;
    tick(); tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall", stall_out, 0);
    check("rst_redirect", redirect, 0);
    check("rst_new_pc", new_pc, 0);
    check("rst_ex_pcp2", ex_pcp2, 0);
    reset = 1'b1;
    tick();

    wb_write(3'd1, 16'd5);
    wb_write(3'd2, 16'd5);
    wb_write(3'd5, 16'hFFFE);
    wb_write(3'd6, 16'd1);
    wb_write(3'd7, 16'hFFFF);

    // Write-through: r3 written in the same cycle ADDI r6,r3,0 is in ID
    feed(16'h0000, enc_i(3'b001, 7'd0, 3'd3, 3'd6));
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h00A5;
    tick();
    wb_we = 1'b0;
    check("wt_rs1v", ex_rs1v, 16'h00A5);
    check("wt_valid", ex_valid, 1);
    check("wt_alusrc", ex_alusrc, 1);
    check("wt_rd", ex_rd_o, 6);

    // Load-use: load to r2 in EX, ADD r4,r2,r1 in ID
    feed(16'h0002, enc_r(4'b0011, 3'd4, 3'd2, 3'd1));
    hz_inputs(1'b1, 1'b1, 3'd2);
    check("lu_stall", stall_out, 1);
    check("lu_redirect", redirect, 0);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_bubble_rw", ex_regwrite_o, 0);
    hz_inputs(1'b0, 1'b0, 3'd0);
    check("lu_stall_clr", stall_out, 0);
    tick();
    check("lu_issue_valid", ex_valid, 1);
    check("lu_issue_rd", ex_rd_o, 4);
    check("lu_issue_aluop", ex_aluop, 3);
    check("lu_issue_rs1v", ex_rs1v, 5);
    check("lu_issue_rs2v", ex_rs2v, 5);

    // Load in EX to r0 never interlocks
    feed(16'h0004, enc_r(4'b0000, 3'd1, 3'd0, 3'd1));
    hz_inputs(1'b1, 1'b1, 3'd0);
    check("r0_no_stall", stall_out, 0);
    tick();
    hz_inputs(1'b0, 1'b0, 3'd0);
    check("r0_rs1v", ex_rs1v, 0);
    check("r0_rs2v", ex_rs2v, 5);

    // Branch-use: ALU producer of r1 in EX, BEQ r1,r2 in ID
    feed(16'h0010, enc_s(3'b100, 7'd3, 3'd1, 3'd2));
    hz_inputs(1'b0, 1'b1, 3'd1);
    check("bu_stall", stall_out, 1);
    check("bu_redirect", redirect, 0);
    check("bu_new_pc", new_pc, 0);
    hz_inputs(1'b0, 1'b0, 3'd0);

    // BEQ taken: pc 0x10, imm 3 -> 0x16; following fetch is flushed
    check("beq_redirect", redirect, 1);
    check("beq_new_pc", new_pc, 16'h0016);
    if_valid = 1'b1; pc_in = 16'h0012; pcp2_in = 16'h0014;
    ir_in = enc_r(4'b0000, 3'd4, 3'd1, 3'd2);
    tick();
    check("beq_ex_valid", ex_valid, 1);
    check("beq_ex_rw", ex_regwrite_o, 0);
    check("beq_ex_mw", ex_memwrite, 0);
    check("beq_ex_imm", ex_imm, 3);
    check("flush_no_redirect", redirect, 0);
    tick();
    if_valid = 1'b0;
    check("flush_bubble", ex_valid, 0);
    tick();

    // BLT r7(-1) < r6(1): taken, pc 0x20 imm -2 -> 0x1C
    feed(16'h0020, enc_s(3'b110, 7'h7E, 3'd7, 3'd6));
    check("blt_redirect", redirect, 1);
    check("blt_new_pc", new_pc, 16'h001C);
    tick();
    // BLT r6(1) < r7(-1): not taken
    feed(16'h0022, enc_s(3'b110, 7'h7E, 3'd6, 3'd7));
    check("blt_nt_redirect", redirect, 0);
    // BNE r1,r2 equal: not taken
    feed(16'h0024, enc_s(3'b101, 7'd3, 3'd1, 3'd2));
    check("bne_nt_redirect", redirect, 0);
    check("bne_nt_new_pc", new_pc, 0);

    // BEQ target wraps past the top of the pc range
    feed(16'hFFFE, enc_s(3'b100, 7'd3, 3'd1, 3'd2));
    check("wrap_new_pc", new_pc, 16'h0004);
    tick();

    // JAL-R with forwarded operand 1: 0x0100 + 4
    fwd1_sel = 1'b1; fwd1_data = 16'h0100;
    feed(16'h0040, enc_i(3'b111, 7'd4, 3'd5, 3'd6));
    check("jal_redirect", redirect, 1);
    check("jal_new_pc", new_pc, 16'h0104);
    tick();
    fwd1_sel = 1'b0;
    check("jal_link", ex_link, 1);
    check("jal_pcp2", ex_pcp2, 16'h0042);
    check("jal_rw", ex_regwrite_o, 1);
    check("jal_imm", ex_imm, 4);
    tick();
    // JAL-R from the register file: 0xFFFE + 4 wraps to 0x0002
    feed(16'h0050, enc_i(3'b111, 7'd4, 3'd5, 3'd6));
    check("jal_rf_new_pc", new_pc, 16'h0002);
    tick();

    // Store with negative immediate 7'h45 -> 0xFFC5
    feed(16'h0060, enc_s(3'b011, 7'h45, 3'd1, 3'd2));
    tick();
    check("st_imm", ex_imm, 16'hFFC5);
    check("st_mw", ex_memwrite, 1);
    check("st_alusrc", ex_alusrc, 1);
    check("st_rw", ex_regwrite_o, 0);

    // Reset for one cycle while valid instructions flow
    feed(16'h0070, enc_r(4'b0000, 3'd4, 3'd3, 3'd1));
    if_valid = 1'b1;
    reset = 1'b0;
    settle();
    check("mrst_ex_valid", ex_valid, 0);
    check("mrst_ex_rs1v", ex_rs1v, 0);
    check("mrst_ex_rw", ex_regwrite_o, 0);
    check("mrst_redirect", redirect, 0);
    tick();
    reset = 1'b1;
    if_valid = 1'b0;
    settle();
    feed(16'h0080, enc_r(4'b0000, 3'd4, 3'd3, 3'd1));
    tick();
    check("mrst_rd_valid", ex_valid, 1);
    check("mrst_r3_zero", ex_rs1v, 0);
    check("mrst_r1_zero", ex_rs2v, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
